// File: rtl/wb_pkg.sv
// Shared write-back definitions: control-bit positions, EPC command encodings,
// the stack-pointer reset value and the redirect FSM state type.
package wb_pkg;

  localparam int unsigned WB_REGWRITE_BIT = 0;
  localparam int unsigned WB_MEMTOREG_BIT = 1;

  localparam logic [31:0] SP_RESET = 32'h000F_FFFF;

  typedef enum logic [1:0] {
    EPC_HOLD  = 2'b00,
    EPC_MEM   = 2'b01,
    EPC_ALU   = 2'b10,
    EPC_CLEAR = 2'b11
  } epc_cmd_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } wb_state_e;

  // Only commands that load a new EPC value request a fetch redirect.
  function automatic logic epc_redirects(input logic [1:0] cmd);
    return (cmd == EPC_MEM) || (cmd == EPC_ALU);
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// General register file: one write port, two combinational read ports.
// Define WB_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int unsigned RegCount = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  raddr1_i,
  input  logic [2:0]  raddr2_i,
  output logic [15:0] rdata1_o,
  output logic [15:0] rdata2_o
);

  logic [15:0] mem_q [RegCount];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RegCount; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned i = 0; i < RegCount; i++) begin
        if (waddr_i == 3'(i)) begin
          mem_q[i] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int unsigned i = 0; i < RegCount; i++) begin
      if (raddr1_i == 3'(i)) rdata1_o = mem_q[i];
      if (raddr2_i == 3'(i)) rdata2_o = mem_q[i];
    end
`ifdef WB_WRITE_BYPASS_EN
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: selects write-back data, owns SP, EPC, the redirect FSM
// and the retired counter. WB_WRITE_BYPASS_EN enables register-file bypass.
module wb_writer
  import wb_pkg::*;
#(
  parameter int unsigned WbSize   = 2,
  parameter int unsigned RegCount = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WbSize-1:0] i_WB,
  input  logic [31:0]       i_MemData,
  input  logic [15:0]       i_alu,
  input  logic [2:0]        i_Rdst,
  input  logic [31:0]       i_SP,
  input  logic [1:0]        i_changeEPC,
  input  logic [2:0]        i_rsrc1,
  input  logic [2:0]        i_rsrc2,
  output logic [15:0]       o_rdata1,
  output logic [15:0]       o_rdata2,
  output logic [15:0]       o_wbData,
  output logic              o_wbValid,
  output logic [31:0]       o_SP,
  output logic [31:0]       o_EPC,
  output logic              o_excRedirect,
  output logic [15:0]       o_retired
);

  wb_state_e   state_q, state_d;
  logic [31:0] sp_q, sp_d;
  logic [31:0] epc_q, epc_d;
  logic [15:0] retired_q, retired_d;

  assign o_wbData  = i_WB[WB_MEMTOREG_BIT] ? i_MemData[15:0] : i_alu;
  assign o_wbValid = enable & i_WB[WB_REGWRITE_BIT];

  wb_regfile #(
    .RegCount (RegCount)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (o_wbValid),
    .waddr_i  (i_Rdst),
    .wdata_i  (o_wbData),
    .raddr1_i (i_rsrc1),
    .raddr2_i (i_rsrc2),
    .rdata1_o (o_rdata1),
    .rdata2_o (o_rdata2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sp_q      <= SP_RESET;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      epc_q     <= epc_d;
      retired_q <= retired_d;
    end
  end

  // A redirect lasts one cycle unless another enabled request arrives.
  always_comb begin
    state_d   = ST_IDLE;
    sp_d      = sp_q;
    epc_d     = epc_q;
    retired_d = retired_q;
    if (enable) begin
      sp_d = i_SP;
      case (i_changeEPC)
        EPC_MEM:   epc_d = i_MemData;
        EPC_ALU:   epc_d = {16'h0000, i_alu};
        EPC_CLEAR: epc_d = '0;
        default:   epc_d = epc_q;
      endcase
      if (|i_WB) retired_d = retired_q + 16'd1;
      if (epc_redirects(i_changeEPC)) state_d = ST_REDIRECT;
    end
  end

  assign o_SP          = sp_q;
  assign o_EPC         = epc_q;
  assign o_retired     = retired_q;
  assign o_excRedirect = (state_q == ST_REDIRECT);

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer; expectations are hand-computed.
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  i_WB;
  logic [31:0] i_MemData;
  logic [15:0] i_alu;
  logic [2:0]  i_Rdst;
  logic [31:0] i_SP;
  logic [1:0]  i_changeEPC;
  logic [2:0]  i_rsrc1;
  logic [2:0]  i_rsrc2;
  logic [15:0] o_rdata1;
  logic [15:0] o_rdata2;
  logic [15:0] o_wbData;
  logic        o_wbValid;
  logic [31:0] o_SP;
  logic [31:0] o_EPC;
  logic        o_excRedirect;
  logic [15:0] o_retired;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_writer #(
    .WbSize   (2),
    .RegCount (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .i_WB          (i_WB),
    .i_MemData     (i_MemData),
    .i_alu         (i_alu),
    .i_Rdst        (i_Rdst),
    .i_SP          (i_SP),
    .i_changeEPC   (i_changeEPC),
    .i_rsrc1       (i_rsrc1),
    .i_rsrc2       (i_rsrc2),
    .o_rdata1      (o_rdata1),
    .o_rdata2      (o_rdata2),
    .o_wbData      (o_wbData),
    .o_wbValid     (o_wbValid),
    .o_SP          (o_SP),
    .o_EPC         (o_EPC),
    .o_excRedirect (o_excRedirect),
    .o_retired     (o_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [2:0] idx, input logic [15:0] exp, input string tag);
    i_rsrc1 = idx;
    i_rsrc2 = idx;
    #1;
    check({tag, "_rd1"}, {16'h0, o_rdata1}, {16'h0, exp});
    check({tag, "_rd2"}, {16'h0, o_rdata2}, {16'h0, exp});
  endtask

  logic [15:0] exp_bypass;

  initial begin
    rst = 1'b1; enable = 1'b0; i_WB = 2'b00; i_MemData = '0; i_alu = '0;
    i_Rdst = '0; i_SP = '0; i_changeEPC = 2'b00; i_rsrc1 = '0; i_rsrc2 = '0;
    #12;
    for (int i = 0; i < 8; i++) begin
      i_rsrc1 = 3'(i);
      i_rsrc2 = 3'(7 - i);
      #1;
      check("rst_reg_p1", {16'h0, o_rdata1}, 32'h0);
      check("rst_reg_p2", {16'h0, o_rdata2}, 32'h0);
    end
    check("rst_sp", o_SP, 32'h000F_FFFF);
    check("rst_epc", o_EPC, 32'h0);
    check("rst_redir", {31'h0, o_excRedirect}, 32'h0);
    check("rst_retired", {16'h0, o_retired}, 32'h0);
    rst = 1'b0;
    #1;

    // ALU write to r5
    enable = 1'b1; i_WB = 2'b01; i_alu = 16'h1234; i_Rdst = 3'd5; i_SP = 32'h0000_1000;
    #1;
    check("wbdata_alu", {16'h0, o_wbData}, 32'h1234);
    check("wbvalid_on", {31'h0, o_wbValid}, 32'h1);
    tick();
    enable = 1'b0;
    read_reg(3'd5, 16'h1234, "w_alu");
    check("sp_load", o_SP, 32'h0000_1000);
    check("retired_1", {16'h0, o_retired}, 32'h1);

    // memory write to r5 selects the low half of the memory word
    enable = 1'b1; i_WB = 2'b11; i_MemData = 32'hABCD_5678;
    #1;
    check("wbdata_mem", {16'h0, o_wbData}, 32'h5678);
    tick();
    enable = 1'b0;
    read_reg(3'd5, 16'h5678, "w_mem");
    check("retired_2", {16'h0, o_retired}, 32'h2);

    // read during write of r5
    enable = 1'b1; i_WB = 2'b01; i_alu = 16'h00FF; i_rsrc1 = 3'd5; i_rsrc2 = 3'd4;
`ifdef WB_WRITE_BYPASS_EN
    exp_bypass = 16'h00FF;
`else
    exp_bypass = 16'h5678;
`endif
    #1;
    check("rdw_r5", {16'h0, o_rdata1}, {16'h0, exp_bypass});
    check("rdw_r4", {16'h0, o_rdata2}, 32'h0);
    tick();
    enable = 1'b0;
    read_reg(3'd5, 16'h00FF, "rdw_after");

    // r0 and r7 are ordinary writable registers
    enable = 1'b1; i_WB = 2'b01; i_alu = 16'hAAAA; i_Rdst = 3'd0;
    tick();
    i_alu = 16'h5555; i_Rdst = 3'd7;
    tick();
    enable = 1'b0;
    read_reg(3'd0, 16'hAAAA, "r0");
    read_reg(3'd7, 16'h5555, "r7");
    read_reg(3'd5, 16'h00FF, "r5_kept");
    check("retired_5", {16'h0, o_retired}, 32'h5);

    // single EPC request: one-cycle pulse, no count without WB, SP still loads
    enable = 1'b1; i_WB = 2'b00; i_changeEPC = 2'b01; i_MemData = 32'h0000_0200;
    i_SP = 32'h0000_0FF0;
    tick();
    check("epc_mem", o_EPC, 32'h0000_0200);
    check("redir_1a", {31'h0, o_excRedirect}, 32'h1);
    check("sp_nowb", o_SP, 32'h0000_0FF0);
    check("retired_nowb", {16'h0, o_retired}, 32'h5);
    i_changeEPC = 2'b00;
    tick();
    check("redir_1b", {31'h0, o_excRedirect}, 32'h0);
    check("epc_hold", o_EPC, 32'h0000_0200);

    // back-to-back requests: two-cycle pulse, EPC rewritten each cycle
    i_changeEPC = 2'b10; i_alu = 16'h0300;
    tick();
    check("epc_alu", o_EPC, 32'h0000_0300);
    check("redir_2a", {31'h0, o_excRedirect}, 32'h1);
    i_changeEPC = 2'b01; i_MemData = 32'h1234_5678;
    tick();
    check("epc_mem2", o_EPC, 32'h1234_5678);
    check("redir_2b", {31'h0, o_excRedirect}, 32'h1);
    i_changeEPC = 2'b00;
    tick();
    check("redir_2c", {31'h0, o_excRedirect}, 32'h0);
    i_changeEPC = 2'b11;
    tick();
    check("epc_clear", o_EPC, 32'h0);
    check("redir_clear", {31'h0, o_excRedirect}, 32'h0);

    // disabled edge changes nothing
    enable = 1'b0; i_WB = 2'b01; i_changeEPC = 2'b10; i_alu = 16'hDEAD;
    i_Rdst = 3'd5; i_SP = 32'h0000_9999;
    #1;
    check("wbvalid_off", {31'h0, o_wbValid}, 32'h0);
    tick();
    read_reg(3'd5, 16'h00FF, "dis_r5");
    check("dis_epc", o_EPC, 32'h0);
    check("dis_sp", o_SP, 32'h0000_0FF0);
    check("dis_retired", {16'h0, o_retired}, 32'h5);
    check("dis_redir", {31'h0, o_excRedirect}, 32'h0);
    tick();
    check("dis_redir2", {31'h0, o_excRedirect}, 32'h0);

    // run the counter up to 0xFFFF, then wrap
    enable = 1'b1; i_WB = 2'b01; i_changeEPC = 2'b00; i_Rdst = 3'd1; i_alu = 16'h0011;
    repeat (65530) tick();
    check("retired_max", {16'h0, o_retired}, 32'h0000_FFFF);
    tick();
    check("retired_wrap", {16'h0, o_retired}, 32'h0);

    // asynchronous reset in the middle of a redirect
    i_WB = 2'b00; i_changeEPC = 2'b01; i_MemData = 32'h0000_0440;
    tick();
    check("pre_rst_redir", {31'h0, o_excRedirect}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_redir", {31'h0, o_excRedirect}, 32'h0);
    check("async_epc", o_EPC, 32'h0);
    check("async_sp", o_SP, 32'h000F_FFFF);
    read_reg(3'd1, 16'h0000, "async_r1");
    rst = 1'b0;

    // first enabled edge after reset behaves normally
    i_WB = 2'b01; i_changeEPC = 2'b00; i_Rdst = 3'd2; i_alu = 16'h4242;
    tick();
    enable = 1'b0;
    read_reg(3'd2, 16'h4242, "post_rst_r2");
    check("post_rst_retired", {16'h0, o_retired}, 32'h1);
    check("post_rst_redir", {31'h0, o_excRedirect}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
